// File: rtl/apb_master_if.sv
// ---------------------------------------------------------------------------
// apb_master_if
// Bundles the command port, the response port and the APB bus segment of
// one APB requester.
//   master modport : the requester's view (apb_master itself)
//   slave  modport : the environment's view (controller + APB slaves)
// Command  : cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_wdata
// Response : rsp_valid/rsp_ready, rsp_rdata, rsp_err, rsp_tmo
// APB      : psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr
// ---------------------------------------------------------------------------
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_tmo;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// APB requester: takes one command at a time from a valid/ready command
// port, runs the APB SETUP and ACCESS phases on a single bus segment and
// returns read data / error status on a valid/ready response port.
// Ports:
//   pclk     clock, rising edge
//   presetn  asynchronous active-low reset
//   bus      apb_master_if.master (command, response and APB signals)
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  ACCESS cycles with pready low before abort (0 = never abort)
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          pclk,
    input  logic          presetn,
    apb_master_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              tmo_hit;

    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_tmo_q;

    // Saturating increment: the counter never wraps inside one transfer.
    assign cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign tmo_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        pwrite_q  <= bus.cmd_write;
                        paddr_q   <= bus.cmd_addr;
                        pwdata_q  <= bus.cmd_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        // prdata is meaningless on a write; return zero.
                        rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                        rsp_err_q   <= bus.pslverr;
                        rsp_tmo_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                        if (tmo_hit) begin
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_tmo_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            psel_q      <= 1'b0;
                            penable_q   <= 1'b0;
                            state_q     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // cmd_ready depends on state only, so the controller may hold
    // cmd_valid while a previous response is still pending.
    assign bus.cmd_ready = (state_q == IDLE);

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_tmo   = rsp_tmo_q;

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
// Directed bench for apb_master (TIMEOUT=8): a vector table of complete
// transfers plus hand-written sequences for response back-pressure and
// reset during ACCESS.
// ---------------------------------------------------------------------------
module tb_apb_master;

    logic pclk;
    logic presetn;

    apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;     // wait states before pready; -1 = never ready
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
        int          exp_acc;    // expected number of ACCESS cycles
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Present a command, accept it at the next edge, check SETUP just after.
    task automatic start_cmd(input vec_t v);
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.write;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        chk1("cmd_ready_idle", bus.cmd_ready, 1'b1);
        @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 32'hFFFF_FFF0;   // must not leak into paddr
        bus.cmd_wdata = 32'hBAD0_BAD0;
        chk1("setup_psel", bus.psel, 1'b1);
        chk1("setup_penable", bus.penable, 1'b0);
        chk1("setup_pwrite", bus.pwrite, v.write);
        chk("setup_paddr", bus.paddr, v.addr);
        if (v.write) chk("setup_pwdata", bus.pwdata, v.wdata);
        chk1("setup_cmd_ready", bus.cmd_ready, 1'b0);
    endtask

    // Called #1 after the SETUP edge; plays the slave through ACCESS.
    task automatic run_access(input vec_t v, output int acc);
        bit done;
        done = 1'b0;
        acc  = 0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b1;              // junk while not ready: must be ignored
        bus.prdata  = 32'h0BAD_F00D;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge pclk);
            #1;
            if (bus.penable) begin
                acc++;
                chk("access_paddr", bus.paddr, v.addr);
                if (v.wait_n >= 0 && acc > v.wait_n) begin
                    bus.pready  = 1'b1;
                    bus.pslverr = v.slverr;
                    bus.prdata  = v.prdata;
                end
            end else begin
                done = 1'b1;
            end
        end
        chk1("resp_reached", done, 1'b1);
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
    endtask

    task automatic check_rsp(input vec_t v, input int acc);
        chk("access_cycles", 32'(acc), 32'(v.exp_acc));
        chk1("resp_valid", bus.rsp_valid, 1'b1);
        chk1("resp_psel", bus.psel, 1'b0);
        chk1("resp_penable", bus.penable, 1'b0);
        chk("resp_rdata", bus.rsp_rdata, v.exp_rdata);
        chk1("resp_err", bus.rsp_err, v.exp_err);
        chk1("resp_tmo", bus.rsp_tmo, v.exp_tmo);
    endtask

    task automatic finish_rsp();
        @(negedge pclk);
        chk1("resp_cmd_ready", bus.cmd_ready, 1'b0);
        bus.rsp_ready = 1'b1;
        @(posedge pclk);
        #1;
        bus.rsp_ready = 1'b0;
        chk1("after_hs_rsp_valid", bus.rsp_valid, 1'b0);
        chk1("after_hs_cmd_ready", bus.cmd_ready, 1'b1);
    endtask

    task automatic do_vec(input vec_t v);
        int acc;
        start_cmd(v);
        run_access(v, acc);
        check_rsp(v, acc);
        finish_rsp();
    endtask

    initial begin
        vec_t v5a;
        vec_t v5b;
        vec_t v6;
        int   acc;

        //            wr    addr          wdata         wait prdata        err   exp_rdata     e_err e_tmo acc
        vecs[0] = '{1'b1, 32'h0000_0004, 32'hA5A5_0001,  0, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h0000_0008, 32'h0000_0000,  3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0000_0000,  0, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 32'h0000_0020, 32'h0000_0000, -1, 32'h5555_5555, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 8};
        vecs[4] = '{1'b1, 32'h0000_0030, 32'h0F0F_F0F0,  7, 32'h7777_7777, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 8};
        vecs[5] = '{1'b0, 32'h0000_0034, 32'h0000_0000,  6, 32'h0123_4567, 1'b0, 32'h0123_4567, 1'b0, 1'b0, 7};
        vecs[6] = '{1'b1, 32'h0000_0038, 32'h3C3C_3C3C, -1, 32'h9999_9999, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 8};

        presetn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        // Reset state
        repeat (3) @(posedge pclk);
        #1;
        chk1("rst_psel", bus.psel, 1'b0);
        chk1("rst_penable", bus.penable, 1'b0);
        chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_paddr", bus.paddr, 32'h0);
        chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
        @(negedge pclk);
        presetn = 1'b1;

        for (int i = 0; i < 7; i++) do_vec(vecs[i]);

        // Response back-pressure with the next command already waiting
        v5a = '{1'b0, 32'h0000_0040, 32'h0, 0, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0, 1'b0, 1};
        v5b = '{1'b1, 32'h0000_0044, 32'h4444_4444, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1};
        start_cmd(v5a);
        run_access(v5a, acc);
        check_rsp(v5a, acc);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v5b.write;
        bus.cmd_addr  = v5b.addr;
        bus.cmd_wdata = v5b.wdata;
        for (int c = 0; c < 5; c++) begin
            @(posedge pclk);
            #1;
            chk1("bp_rsp_valid", bus.rsp_valid, 1'b1);
            chk("bp_rsp_rdata", bus.rsp_rdata, 32'h1111_2222);
            chk1("bp_cmd_ready", bus.cmd_ready, 1'b0);
            chk1("bp_psel", bus.psel, 1'b0);
        end
        @(negedge pclk);
        bus.rsp_ready = 1'b1;
        @(posedge pclk);
        #1;
        bus.rsp_ready = 1'b0;
        chk1("bp_hs_rsp_valid", bus.rsp_valid, 1'b0);
        chk1("bp_hs_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b0;
        chk1("bp_next_psel", bus.psel, 1'b1);
        chk("bp_next_paddr", bus.paddr, 32'h0000_0044);
        chk("bp_next_pwdata", bus.pwdata, 32'h4444_4444);
        run_access(v5b, acc);
        check_rsp(v5b, acc);
        finish_rsp();

        // Reset asserted in the middle of ACCESS
        v6 = '{1'b0, 32'h0000_0050, 32'h0, -1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 8};
        start_cmd(v6);
        @(posedge pclk);
        #1;
        chk1("pre_rst_penable", bus.penable, 1'b1);
        #2;
        presetn = 1'b0;
        #1;
        chk1("async_rst_psel", bus.psel, 1'b0);
        chk1("async_rst_penable", bus.penable, 1'b0);
        chk1("async_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk1("async_rst_cmd_ready", bus.cmd_ready, 1'b1);
        @(negedge pclk);
        presetn = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        chk1("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk1("post_rst_psel", bus.psel, 1'b0);
        chk1("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
        do_vec(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
